// File: rtl/sr_ff_pkg.sv
// sr_ff_pkg
// Shared definitions for the SR flip-flop bank.
//   sr_action_e  : action a bit takes at a clock edge, decoded from {s,r}
//   SR_MAX_WIDTH : largest legal WIDTH of sr_ff_sync_rst
//   sr_decode    : maps one set/reset pair onto an sr_action_e
package sr_ff_pkg;

    localparam int SR_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        SR_HOLD     = 2'b00,
        SR_RESET    = 2'b01,
        SR_SET      = 2'b10,
        SR_CONFLICT = 2'b11
    } sr_action_e;

    function automatic sr_action_e sr_decode(input logic s, input logic r);
        sr_action_e action;
        case ({s, r})
            2'b01:   action = SR_RESET;
            2'b10:   action = SR_SET;
            2'b11:   action = SR_CONFLICT;
            default: action = SR_HOLD;
        endcase
        return action;
    endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// sr_ff_cell
// One clocked SR flip-flop bit with synchronous, active-low reset.
// Optional macro: SRFF_CONFLICT_FLAG_EN adds the registered conflict output.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active low
//   s, r     in   set / reset request
//   rst_val  in   value loaded into q by reset
//   q        out  registered state
//   conflict out  registered s=r=1 flag (macro builds only)
module sr_ff_cell
    import sr_ff_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    input  logic rst_val,
`ifdef SRFF_CONFLICT_FLAG_EN
    output logic q,
    output logic conflict
`else
    output logic q
`endif
);

    sr_action_e action;

    assign action = sr_decode(s, r);

    // State register: reset dominates; s=r=1 holds like s=r=0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= rst_val;
        end else begin
            case (action)
                SR_RESET: q <= 1'b0;
                SR_SET:   q <= 1'b1;
                default:  q <= q;
            endcase
        end
    end

`ifdef SRFF_CONFLICT_FLAG_EN
    // Conflict flag mirrors the s=r=1 condition of the cycle just sampled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            conflict <= 1'b0;
        end else begin
            conflict <= (action == SR_CONFLICT);
        end
    end
`endif

endmodule

// File: rtl/sr_ff_sync_rst.sv
// sr_ff_sync_rst
// Parameterised bank of independent clocked SR flip-flops with synchronous,
// active-low reset. Each bit is an sr_ff_cell.
// Optional macro: SRFF_CONFLICT_FLAG_EN adds conflict and conflict_any.
// Parameters:
//   WIDTH    number of bits, 1..SR_MAX_WIDTH
//   RST_VAL  value loaded into q by reset
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous reset, active low
//   s, r          in   per-bit set / reset requests
//   q             out  registered state
//   q_n           out  ~q
//   conflict      out  per-bit registered s=r=1 flag (macro builds only)
//   conflict_any  out  sticky "any conflict since reset" (macro builds only)
module sr_ff_sync_rst
    import sr_ff_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
`ifdef SRFF_CONFLICT_FLAG_EN
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] conflict,
    output logic             conflict_any
`else
    output logic [WIDTH-1:0] q_n
`endif
);

    if (WIDTH < 1 || WIDTH > SR_MAX_WIDTH) begin : g_bad_width
        $error("sr_ff_sync_rst: WIDTH %0d outside 1..%0d", WIDTH, SR_MAX_WIDTH);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_ff_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .s        (s[i]),
            .r        (r[i]),
            .rst_val  (RST_VAL[i]),
`ifdef SRFF_CONFLICT_FLAG_EN
            .q        (q[i]),
            .conflict (conflict[i])
`else
            .q        (q[i])
`endif
        );
    end

    assign q_n = ~q;

`ifdef SRFF_CONFLICT_FLAG_EN
    // Sticky flag sets on the same edge as the per-bit conflict flags, so it
    // looks at the inputs rather than the already-registered conflict bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            conflict_any <= 1'b0;
        end else if (|(s & r)) begin
            conflict_any <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sr_ff_sync_rst.sv
// tb_sr_ff_sync_rst
// Self-checking bench for sr_ff_sync_rst (WIDTH=4, RST_VAL=4'b1010).
// Works in both builds; conflict outputs are checked when
// SRFF_CONFLICT_FLAG_EN is defined.
module tb_sr_ff_sync_rst;

    localparam int         W  = 4;
    localparam logic [W-1:0] RV = 4'b1010;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] s   = '0;
    logic [W-1:0] r   = '0;
    logic [W-1:0] q;
    logic [W-1:0] q_n;
`ifdef SRFF_CONFLICT_FLAG_EN
    logic [W-1:0] conflict;
    logic         conflict_any;
`endif

    // Reference state: model value, which bits are defined, conflict view.
    logic [W-1:0] mq       = '0;
    logic [W-1:0] known    = '0;
    logic [W-1:0] mc       = '0;
    logic         many     = 1'b0;
    logic         manyKnown = 1'b0;

    int testsRun  = 0;
    int failCount = 0;

    sr_ff_sync_rst #(
        .WIDTH   (W),
        .RST_VAL (RV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s            (s),
        .r            (r),
        .q            (q),
`ifdef SRFF_CONFLICT_FLAG_EN
        .q_n          (q_n),
        .conflict     (conflict),
        .conflict_any (conflict_any)
`else
        .q_n          (q_n)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model at the
    // rising edge using the set/clear rules, then settle 1 ns past the edge.
    task automatic applyStimulus(input logic rstIn, input logic [W-1:0] sIn,
                                 input logic [W-1:0] rIn);
        logic [W-1:0] setBits;
        logic [W-1:0] clrBits;
        @(negedge clk);
        rst = rstIn;
        s   = sIn;
        r   = rIn;
        @(posedge clk);
        if (!rstIn) begin
            mq        = RV;
            known     = '1;
            mc        = '0;
            many      = 1'b0;
            manyKnown = 1'b1;
        end else begin
            setBits = sIn & ~rIn;
            clrBits = rIn & ~sIn;
            mq      = (mq | setBits) & ~clrBits;
            known   = known | setBits | clrBits;
            mc      = sIn & rIn;
            many    = many | (|(sIn & rIn));
        end
        #1;
    endtask

    // Compare every defined output against the model.
    task automatic checkOutput(input string tag);
        if (known != '0) begin
            checkValue({tag, ".q"},   q & known,   mq & known);
            checkValue({tag, ".q_n"}, q_n & known, ~mq & known);
        end
`ifdef SRFF_CONFLICT_FLAG_EN
        checkValue({tag, ".conflict"}, conflict, mc);
        if (manyKnown) begin
            checkValue({tag, ".conflict_any"}, {{(W-1){1'b0}}, conflict_any},
                       {{(W-1){1'b0}}, many});
        end
`endif
    endtask

    initial begin
        // s/r = 00, 01, 10, 11 with no reset sampled: X, 0, 1, 1.
        applyStimulus(1'b1, 4'h0, 4'h0);
        checkOutput("pre_sr00");
        applyStimulus(1'b1, 4'h0, 4'hF);
        checkValue("sr01.q", q, 4'b0000);
        checkValue("sr01.q_n", q_n, 4'b1111);
        applyStimulus(1'b1, 4'hF, 4'h0);
        checkValue("sr10.q", q, 4'b1111);
        applyStimulus(1'b1, 4'hF, 4'hF);
        checkValue("sr11_hold.q", q, 4'b1111);
        checkValue("sr11_hold.q_n", q_n, 4'b0000);
        checkOutput("sr11");

        // Reset dominates an active set, then release lets the set through.
        applyStimulus(1'b0, 4'hF, 4'h0);
        checkValue("rst_dom.q", q, RV);
        applyStimulus(1'b0, 4'hF, 4'h0);
        checkValue("rst_2cyc.q", q, 4'b1010);
        checkValue("rst_2cyc.q_n", q_n, 4'b0101);
        checkOutput("rst");
        applyStimulus(1'b1, 4'hF, 4'h0);
        checkValue("rst_release.q", q, 4'b1111);

        // Reset for 2 cycles, then per-bit set and reset.
        applyStimulus(1'b0, 4'h0, 4'h0);
        applyStimulus(1'b0, 4'h0, 4'h0);
        applyStimulus(1'b1, 4'b0001, 4'b1000);
        checkValue("bitwise.q", q, 4'b0011);
        checkOutput("bitwise");

        // Reset glitch entirely between two rising edges is not sampled.
        s = '0;
        r = '0;
        #1 rst = 1'b0;
        #3 rst = 1'b1;
        applyStimulus(1'b1, 4'h0, 4'h0);
        checkValue("glitch.q", q, 4'b0011);
        checkOutput("glitch");

        // Conflict sequence: clear, then s=0011 r=0001, then idle, then reset.
        applyStimulus(1'b1, 4'h0, 4'b0011);
        checkValue("clr_low.q", q, 4'b0000);
        applyStimulus(1'b1, 4'b0011, 4'b0001);
        checkValue("conflict_hold.q", q, 4'b0010);
        checkOutput("conflict");
`ifdef SRFF_CONFLICT_FLAG_EN
        checkValue("conflict.flag", conflict, 4'b0001);
        checkValue("conflict.any", {3'b000, conflict_any}, 4'b0001);
`endif
        applyStimulus(1'b1, 4'h0, 4'h0);
        checkOutput("conflict_idle");
`ifdef SRFF_CONFLICT_FLAG_EN
        checkValue("conflict_idle.flag", conflict, 4'b0000);
        checkValue("conflict_idle.any", {3'b000, conflict_any}, 4'b0001);
`endif
        applyStimulus(1'b0, 4'h0, 4'h0);
        checkOutput("conflict_rst");
`ifdef SRFF_CONFLICT_FLAG_EN
        checkValue("conflict_rst.any", {3'b000, conflict_any}, 4'b0000);
`endif

        // Randomised cycles with occasional reset.
        for (int i = 0; i < 100; i++) begin
            applyStimulus(($urandom_range(0, 7) != 0), W'($urandom), W'($urandom));
            checkOutput($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
